// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with load-use hazard detection, one-bubble insertion,
// freeze/flush handling and a saturating bubble counter.
module id_exe_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,

  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [CMD_W-1:0]  id_exe_cmd,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_is_imm,
  input  logic [1:0]        id_br_type,

  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_pc,
  output logic [DATA_W-1:0] exe_val1,
  output logic [DATA_W-1:0] exe_val2,
  output logic [REG_AW-1:0] exe_src1,
  output logic [REG_AW-1:0] exe_src2,
  output logic [REG_AW-1:0] exe_dest,
  output logic [CMD_W-1:0]  exe_exe_cmd,
  output logic              exe_wb_en,
  output logic              exe_mem_r_en,
  output logic              exe_mem_w_en,
  output logic              exe_is_imm,
  output logic [1:0]        exe_br_type,

  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [1:0] BrBne = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic [CMD_W-1:0]  exe_cmd;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              is_imm;
    logic [1:0]        br_type;
  } pipe_t;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StBubble = 1'b1
  } state_e;

  state_e           state_q, state_d;
  pipe_t            pipe_q, pipe_d, id_bundle;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic uses_src2;
  logic raw_hazard;
  logic load_bubble;
  logic load_id;
  logic count_bubble;

  assign id_bundle = '{
    valid:    id_valid,
    pc:       id_pc,
    val1:     id_val1,
    val2:     id_val2,
    src1:     id_src1,
    src2:     id_src2,
    dest:     id_dest,
    exe_cmd:  id_exe_cmd,
    wb_en:    id_wb_en,
    mem_r_en: id_mem_r_en,
    mem_w_en: id_mem_w_en,
    is_imm:   id_is_imm,
    br_type:  id_br_type
  };

  // BNE compares both registers and stores read src2 as data, even with an immediate.
  assign uses_src2 = ~id_is_imm | (id_br_type == BrBne) | id_mem_w_en;

  assign raw_hazard = pipe_q.valid & pipe_q.mem_r_en & pipe_q.wb_en &
                      (pipe_q.dest != '0) & id_valid &
                      ((id_src1 == pipe_q.dest) | (uses_src2 & (id_src2 == pipe_q.dest)));

  assign hazard_stall = (state_q == StRun) & raw_hazard & ~flush;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else if (!freeze) begin
      unique case (state_q)
        StRun:    state_d = hazard_stall ? StBubble : StRun;
        StBubble: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  // FSM outputs: what the pipeline register does at the next edge
  always_comb begin
    load_bubble  = 1'b0;
    load_id      = 1'b0;
    count_bubble = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (!freeze) begin
      unique case (state_q)
        StRun: begin
          load_bubble  = hazard_stall;
          count_bubble = hazard_stall;
          load_id      = ~hazard_stall;
        end
        StBubble: load_id = 1'b1;
        default:  load_id = 1'b1;
      endcase
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if (load_bubble) begin
      pipe_d = '0;
    end else if (load_id) begin
      pipe_d = id_bundle;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_bubble && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exe_valid    = pipe_q.valid;
  assign exe_pc       = pipe_q.pc;
  assign exe_val1     = pipe_q.val1;
  assign exe_val2     = pipe_q.val2;
  assign exe_src1     = pipe_q.src1;
  assign exe_src2     = pipe_q.src2;
  assign exe_dest     = pipe_q.dest;
  assign exe_exe_cmd  = pipe_q.exe_cmd;
  assign exe_wb_en    = pipe_q.wb_en;
  assign exe_mem_r_en = pipe_q.mem_r_en;
  assign exe_mem_w_en = pipe_q.mem_w_en;
  assign exe_is_imm   = pipe_q.is_imm;
  assign exe_br_type  = pipe_q.br_type;
  assign bubble_count = cnt_q;

endmodule
